// File: rtl/sm_fixed_pkg.sv
// Shared sign-magnitude Q7.8 types, constants and conversion helpers
// for the LSTM fixed-point datapath.
package sm_fixed_pkg;

   localparam int WIDTH     = 16;
   localparam int FRAC_BITS = 8;
   localparam int ACC_W     = 24;
   localparam int CNT_W     = 8;

   localparam logic [WIDTH-2:0] MAX_MAG = 15'h7FFF;

   typedef struct packed {
      logic             sign;
      logic [WIDTH-2:0] mag;
   } sm_word_t;

   typedef enum logic [1:0] {
      ST_ACC   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   // Sign-magnitude word (sign at bit width-1) to ACC_W two's complement.
   // A zero magnitude maps to 0 whatever the sign bit says.
   function automatic logic signed [ACC_W-1:0] sm_to_tc(
      input logic [31:0] word,
      input int          width
   );
      logic [ACC_W-1:0] mag;
      logic             sgn;
      mag = '0;
      for (int i = 0; i < ACC_W; i++) begin
         if (i < width - 1) mag[i] = word[i];
      end
      sgn = |(word & (32'd1 << (width - 1)));
      if (sgn) return -$signed(mag);
      return $signed(mag);
   endfunction

   // Two's complement to sign-magnitude with magnitude clamp.
   // Returns {overflow, word}; zero is always +0.
   function automatic logic [WIDTH:0] tc_to_sm_sat(
      input logic signed [ACC_W-1:0] value
   );
      logic             sgn;
      logic [ACC_W-1:0] mag;
      sgn = value[ACC_W-1];
      mag = sgn ? $unsigned(-value) : $unsigned(value);
      if (mag > {{(ACC_W-WIDTH+1){1'b0}}, MAX_MAG})
         return {1'b1, sgn, MAX_MAG};
      if (mag == '0)
         return '0;
      return {1'b0, sgn, mag[WIDTH-2:0]};
   endfunction

endpackage

// File: rtl/sm_multiplier.sv
// Combinational sign-magnitude Q7.8 multiply with truncation toward
// zero and a positive sign forced on a zero product.
module sm_multiplier
   import sm_fixed_pkg::*;
#(
   parameter int W  = WIDTH,
   parameter int F  = FRAC_BITS,
   parameter int PW = 2*(W-1) - F
) (
   input  logic [W-1:0]  op_a,
   input  logic [W-1:0]  op_b,
   output logic          p_sign,
   output logic [PW-1:0] p_mag
);

   localparam int MW = 2*(W-1);

   logic [MW-1:0] ext_a;
   logic [MW-1:0] ext_b;
   logic [MW-1:0] full;

   assign ext_a  = MW'(op_a[W-2:0]);
   assign ext_b  = MW'(op_b[W-2:0]);
   assign full   = ext_a * ext_b;
   assign p_mag  = PW'(full >> F);
   assign p_sign = (op_a[W-1] ^ op_b[W-1]) & (|p_mag);

endmodule

// File: rtl/sm_dot_accumulator.sv
// Streaming sign-magnitude dot product: multiply, saturating accumulate
// over an in_last-delimited vector, emit one clamped Q7.8 result.
module sm_dot_accumulator
   import sm_fixed_pkg::*;
#(
   parameter int WIDTH     = sm_fixed_pkg::WIDTH,
   parameter int FRAC_BITS = sm_fixed_pkg::FRAC_BITS,
   parameter int ACC_WIDTH = sm_fixed_pkg::ACC_W,
   parameter int CNT_WIDTH = sm_fixed_pkg::CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_overflow,
   output logic [CNT_WIDTH-1:0] elem_count
);

   localparam int PW = 2*(WIDTH-1) - FRAC_BITS;

   localparam logic signed [ACC_WIDTH:0] POS_LIM =
      $signed({2'b00, {(ACC_WIDTH-1){1'b1}}});
   localparam logic signed [ACC_WIDTH:0] NEG_LIM = -POS_LIM;

   state_t state_q;
   state_t state_d;

   logic                        flush_q;
   logic                        xfer;
   logic                        flush_done;
   logic                        out_hs;

   logic                        m_sign;
   logic [PW-1:0]               m_mag;
   logic signed [ACC_WIDTH-1:0] m_tc;

   logic                        prod_vld_q;
   logic signed [ACC_WIDTH-1:0] prod_q;

   logic signed [ACC_WIDTH-1:0] acc_q;
   logic                        sticky_q;
   logic signed [ACC_WIDTH:0]   sum_w;
   logic signed [ACC_WIDTH-1:0] sat_sum;
   logic                        sat_hit;
   logic signed [ACC_WIDTH-1:0] acc_next;
   logic                        sticky_next;

   logic [WIDTH:0]              res_conv;
   sm_word_t                    res_word;
   logic                        res_ovf;

   sm_word_t                    out_word_q;
   logic                        out_ovf_q;
   logic [CNT_WIDTH-1:0]        cnt_q;

   sm_multiplier #(
      .W  (WIDTH),
      .F  (FRAC_BITS),
      .PW (PW)
   ) u_mul (
      .op_a   (in_a),
      .op_b   (in_b),
      .p_sign (m_sign),
      .p_mag  (m_mag)
   );

   assign m_tc = sm_to_tc(32'({m_sign, m_mag}), PW + 1);

   // Next-state and handshake outputs.
   always_comb begin
      state_d    = state_q;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      flush_done = 1'b0;
      unique case (state_q)
         ST_ACC: begin
            in_ready = 1'b1;
            if (in_valid && in_last) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (flush_q) begin
               flush_done = 1'b1;
               state_d    = ST_HOLD;
            end
         end
         ST_HOLD: begin
            out_valid = 1'b1;
            if (out_ready) state_d = ST_ACC;
         end
         default: state_d = ST_ACC;
      endcase
   end

   assign xfer   = in_valid & in_ready;
   assign out_hs = out_valid & out_ready;

   // Saturating accumulate of the registered product.
   always_comb begin
      sum_w   = {acc_q[ACC_WIDTH-1], acc_q}
              + {prod_q[ACC_WIDTH-1], prod_q};
      sat_sum = sum_w[ACC_WIDTH-1:0];
      sat_hit = 1'b0;
      if (sum_w > POS_LIM) begin
         sat_sum = POS_LIM[ACC_WIDTH-1:0];
         sat_hit = 1'b1;
      end else if (sum_w < NEG_LIM) begin
         sat_sum = NEG_LIM[ACC_WIDTH-1:0];
         sat_hit = 1'b1;
      end
      acc_next    = prod_vld_q ? sat_sum : acc_q;
      sticky_next = sticky_q | (prod_vld_q & sat_hit);
   end

   // Result formatting from the final sum, including the last product.
   always_comb begin
      res_conv = tc_to_sm_sat(acc_next);
      res_word = res_conv[WIDTH-1:0];
      res_ovf  = res_conv[WIDTH];
      if (sticky_next) begin
         res_word.sign = acc_next[ACC_WIDTH-1];
         res_word.mag  = MAX_MAG;
         res_ovf       = 1'b1;
      end
   end

   // State register and flush-cycle counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_ACC;
         flush_q <= 1'b0;
      end else begin
         state_q <= state_d;
         flush_q <= (state_q == ST_FLUSH) ? ~flush_q : 1'b0;
      end
   end

   // Stage 1: registered product.
   always_ff @(posedge clk) begin
      if (rst) begin
         prod_vld_q <= 1'b0;
         prod_q     <= '0;
      end else begin
         prod_vld_q <= xfer;
         if (xfer) prod_q <= m_tc;
      end
   end

   // Stage 2: accumulator and sticky saturation flag.
   always_ff @(posedge clk) begin
      if (rst || out_hs) begin
         acc_q    <= '0;
         sticky_q <= 1'b0;
      end else begin
         acc_q    <= acc_next;
         sticky_q <= sticky_next;
      end
   end

   // Result register, held until the output handshake.
   always_ff @(posedge clk) begin
      if (rst || out_hs) begin
         out_word_q <= '0;
         out_ovf_q  <= 1'b0;
      end else if (flush_done) begin
         out_word_q <= res_word;
         out_ovf_q  <= res_ovf;
      end
   end

   // Element counter, wraps silently.
   always_ff @(posedge clk) begin
      if (rst || out_hs) begin
         cnt_q <= '0;
      end else if (xfer) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign out_data     = out_word_q;
   assign out_overflow = out_ovf_q;
   assign elem_count   = cnt_q;

endmodule

// File: tb/tb_sm_dot_accumulator.sv
// Scoreboard bench for sm_dot_accumulator: expected results are queued
// as pairs are driven and popped when the DUT presents a result.
module tb_sm_dot_accumulator;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_overflow;
   logic [7:0]  elem_count;

   int n_checks = 0;
   int n_fail   = 0;

   longint      m_acc    = 0;
   bit          m_sticky = 0;
   logic [16:0] exp_q[$];

   sm_dot_accumulator dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_a         (in_a),
      .in_b         (in_b),
      .in_last      (in_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_overflow (out_overflow),
      .elem_count   (elem_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_pair(input logic [15:0] a, input logic [15:0] b,
                             input logic last);
      longint p;
      longint mag;
      bit     sgn;
      p = (longint'(a[14:0]) * longint'(b[14:0])) >>> 8;
      if (a[15] ^ b[15]) p = -p;
      m_acc = m_acc + p;
      if (m_acc > 64'sd8388607) begin
         m_acc = 8388607;
         m_sticky = 1;
      end else if (m_acc < -64'sd8388607) begin
         m_acc = -8388607;
         m_sticky = 1;
      end
      if (last) begin
         sgn = (m_acc < 0);
         mag = sgn ? -m_acc : m_acc;
         if (m_sticky || mag > 32767)
            exp_q.push_back({1'b1, sgn, 15'h7FFF});
         else if (mag == 0)
            exp_q.push_back(17'h0);
         else
            exp_q.push_back({1'b0, sgn, mag[14:0]});
         m_acc = 0;
         m_sticky = 0;
      end
   endtask

   task automatic send(input logic [15:0] a, input logic [15:0] b,
                       input logic last);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      in_last = last;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL send_ready: in_ready=%b required 1", in_ready);
      end
      @(posedge clk); #1;
      model_pair(a, b, last);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic get_result(output logic [16:0] got);
      int n;
      logic [16:0] exp;
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      got = {out_overflow, out_data};
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL result_timeout: out_valid=%b required 1",
                  out_valid);
      end
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: got %h required none", got);
      end else begin
         exp = exp_q.pop_front();
         if (got !== exp) begin
            n_fail++;
            $display("FAIL scoreboard: ovf,data=%h required %h", got, exp);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || elem_count !== 8'd0) begin
         n_fail++;
         $display("FAIL post_handshake: rdy=%b vld=%b cnt=%0d required 1 0 0",
                  in_ready, out_valid, elem_count);
      end
   endtask

   task automatic chk(input string name, input logic [16:0] got,
                      input logic [16:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0 ||
          out_overflow !== 1'b0 || elem_count !== 8'd0) begin
         n_fail++;
         $display("FAIL reset: rdy=%b vld=%b data=%h ovf=%b cnt=%0d required 1 0 0000 0 0",
                  in_ready, out_valid, out_data, out_overflow, elem_count);
      end
   endtask

   task automatic test_single();
      logic [16:0] got;
      send(16'h0200, 16'h8180, 1'b1);
      idle();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL latency_t0: vld=%b rdy=%b required 0 0",
                  out_valid, in_ready);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL latency_t1: out_valid=%b required 0", out_valid);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL latency_t2: out_valid=%b required 1", out_valid);
      end
      get_result(got);
      chk("single_pair", got, 17'h08300);
   endtask

   task automatic test_accumulate();
      logic [16:0] got;
      for (int i = 0; i < 4; i++) send(16'h0100, 16'h0100, i == 3);
      idle();
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_checks++;
      if (elem_count !== 8'd4) begin
         n_fail++;
         $display("FAIL elem_count: got %0d required 4", elem_count);
      end
      get_result(got);
      chk("four_ones", got, 17'h00400);
      send(16'h0001, 16'h0001, 1'b1);
      idle();
      get_result(got);
      chk("truncation", got, 17'h00000);
   endtask

   task automatic test_saturation();
      logic [16:0] got;
      for (int i = 0; i < 4; i++) send(16'h7F00, 16'h0200, i == 3);
      idle();
      get_result(got);
      chk("sat_pos", got, 17'h17FFF);
      for (int i = 0; i < 4; i++) send(16'h7F00, 16'h8200, i == 3);
      idle();
      get_result(got);
      chk("sat_neg", got, 17'h1FFFF);
   endtask

   task automatic test_cancel();
      logic [16:0] got;
      send(16'h0100, 16'h0100, 1'b0);
      send(16'h8100, 16'h0100, 1'b1);
      idle();
      get_result(got);
      chk("cancel_zero", got, 17'h00000);
      send(16'h8000, 16'h0100, 1'b1);
      idle();
      get_result(got);
      chk("neg_zero_in", got, 17'h00000);
   endtask

   task automatic test_backpressure();
      logic [16:0] got;
      int n;
      send(16'h0100, 16'h0100, 1'b1);
      idle();
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b1;
      in_a = 16'h0500;
      in_b = 16'h0100;
      in_last = 1'b1;
      out_ready = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         n_checks++;
         if (out_data !== 16'h0100 || in_ready !== 1'b0 ||
             out_valid !== 1'b1 || elem_count !== 8'd1) begin
            n_fail++;
            $display("FAIL backpressure: data=%h rdy=%b vld=%b cnt=%0d required 0100 0 1 1",
                     out_data, in_ready, out_valid, elem_count);
         end
      end
      idle();
      get_result(got);
      chk("bp_result", got, 17'h00100);
      send(16'h0200, 16'h0100, 1'b1);
      idle();
      get_result(got);
      chk("bp_next", got, 17'h00200);
   endtask

   task automatic test_mid_reset();
      logic [16:0] got;
      send(16'h0100, 16'h0100, 1'b0);
      send(16'h0100, 16'h0100, 1'b0);
      idle();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_acc = 0;
      m_sticky = 0;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0 ||
          out_overflow !== 1'b0 || elem_count !== 8'd0) begin
         n_fail++;
         $display("FAIL mid_reset: rdy=%b vld=%b data=%h ovf=%b cnt=%0d required 1 0 0000 0 0",
                  in_ready, out_valid, out_data, out_overflow, elem_count);
      end
      send(16'h0300, 16'h0100, 1'b1);
      idle();
      get_result(got);
      chk("after_reset", got, 17'h00300);
   endtask

   task automatic test_back_to_back();
      logic [16:0] got;
      int len;
      for (int v = 0; v < 6; v++) begin
         len = $urandom_range(1, 6);
         for (int i = 0; i < len; i++)
            send(16'($urandom), 16'($urandom_range(0, 16'h03FF)) |
                 (16'($urandom_range(0, 1)) << 15), i == len - 1);
         idle();
         get_result(got);
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      in_last = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_single();
      test_accumulate();
      test_saturation();
      test_cancel();
      test_backpressure();
      test_mid_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sm_dot_accumulator.md
Name: sm_dot_accumulator

Overview:
Streaming dot-product stage for the LSTM datapath. It consumes sign-magnitude Q7.8 operand pairs, typically the difference outputs of the subtractor stage paired with gate weights or activations. It multiplies each pair, accumulates the products over a vector delimited by in_last, and emits one saturated sign-magnitude Q7.8 result per vector over a valid/ready handshake.

Parameters:
WIDTH, 16, operand/result width (1 sign + 7 integer + 8 fraction, sign-magnitude)
FRAC_BITS, 8, fractional bits; product is shifted right by this amount
ACC_WIDTH, 24, internal two's-complement accumulator width
CNT_WIDTH, 8, width of element counter

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept a pair this cycle
in_a  in  WIDTH  operand A, sign-magnitude Q7.8
in_b  in  WIDTH  operand B, sign-magnitude Q7.8
in_last  in  1  marks final pair of the current vector
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  WIDTH  dot-product result, sign-magnitude Q7.8
out_overflow  out  1  result was saturated (qualified by out_valid)
elem_count  out  CNT_WIDTH  pairs accepted in current vector (wraps at 2^CNT_WIDTH)

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high. On reset: state=ACC, in_ready=1, out_valid=0, out_data=0, out_overflow=0, elem_count=0, accumulator=0, product stage invalid.
- Reset mid-vector discards all partial sums and any pending result.
- Accept rule: a pair transfers when in_valid && in_ready.
- States:
  - ACC: in_ready=1. On transfer with in_last, go to FLUSH.
  - FLUSH: in_ready=0 for 2 cycles while the product and final sum complete, then go to HOLD.
  - HOLD: out_valid=1, in_ready=0. On out_ready, go to ACC and clear the accumulator, elem_count and out_overflow. in_ready is 1 the cycle after the handshake.
- Stage 1 (registered):
  - mag_p = mag_a * mag_b (2*(WIDTH-1) bits), then >> FRAC_BITS, truncating toward zero.
  - sign = sign_a ^ sign_b. A zero magnitude product is positive.
  - The product is converted to ACC_WIDTH two's complement. -0 inputs are treated as 0.
- Stage 2 (registered): acc <= acc + product.
  - The sum saturates at ±(2^(ACC_WIDTH-1)-1).
  - Saturation sets a sticky internal flag.
- Result:
  - Formed from the final accumulator value (including the last product).
  - If |acc| > 2^(WIDTH-1)-1 or the sticky flag is set: magnitude = 0x7FFF, sign kept, out_overflow=1.
  - Otherwise the exact magnitude is used.
  - A zero result is always 0x0000, never 0x8000.
- Latency: last pair accepted at edge T. Product registered at T+1, result registered at T+2. out_valid is high from T+2 until the handshake.
- Backpressure: out_data and out_overflow hold stable while out_valid && !out_ready.
- elem_count increments per accepted pair and is cleared on the output handshake. Wrap-around is silent and does not affect the result.
- in_valid while in_ready=0 is ignored; no data is lost because the upstream stage holds.

Decomposition:
- Shared package (sm_fixed_pkg):
  - constants WIDTH, FRAC_BITS, MAX_MAG=0x7FFF
  - typedef for the sign-magnitude word
  - functions sm_to_tc(word, width) and tc_to_sm_sat(value) returning {overflow, word}
- One sub-module: sm_multiplier, a combinational sign-magnitude Q7.8 multiply with truncation and zero-sign normalisation, reusable by other gates.

Test Plan:
1. Single pair, in_a=0x0200 (2.0), in_b=0x8180 (-1.5), in_last=1 -> out_data=0x8300 (-3.0), out_overflow=0, out_valid 2 cycles after accept.
2. Four pairs of 0x0100*0x0100 (1.0*1.0), last on the 4th -> out_data=0x0400, elem_count=4 before handshake; 0x0001*0x0001 as a single vector -> 0x0000 (truncation).
3. Saturation:
   - four pairs of 0x7F00*0x0200 (127*2) -> out_data=0x7FFF, out_overflow=1
   - same with in_b=0x8200 -> out_data=0xFFFF, out_overflow=1
4. Cancellation: 0x0100*0x0100 then 0x8100*0x0100 (last) -> out_data=0x0000, not 0x8000; -0 input 0x8000*0x0100 -> 0x0000.
5. Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> out_data stable, in_ready=0, no pair accepted; raise out_ready -> handshake, in_ready=1 next cycle, next vector result independent.
6. Assert rst after 2 pairs of 0x0100*0x0100 -> all outputs at reset values next cycle; following vector 0x0300*0x0100 (last) -> out_data=0x0300.
